// File: rtl/enemy_row_controller.sv
// One enemy row: alive/dying/dead lifecycle, movement step divider and 4-phase
// sweep sequencing; the per-row move stage computes the next position externally.
module enemy_row_controller #(
  parameter logic [9:0]  NONE            = 10'h3FF,
  parameter logic [9:0]  START_X         = 10'd100,
  parameter logic [19:0] MOVE_DIV        = 20'd500000,
  parameter logic [5:0]  STEPS_PER_PHASE = 6'd32,
  parameter logic [19:0] DIE_CYCLES      = 20'd1000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Enable,
  input  logic       i_Hit,
  input  logic       i_Respawn,
  input  logic [9:0] i_NextHorizontalPosition,
  output logic       o_EnemyState,
  output logic [9:0] o_EnemyHorizontalPosition,
  output logic [1:0] o_PhaseState,
  output logic       o_MoveTick
);

  typedef enum logic [1:0] {
    ALIVE = 2'd0,
    DYING = 2'd1,
    DEAD  = 2'd2
  } state_e;

  localparam logic [19:0] DIV_LAST  = MOVE_DIV - 20'd1;
  localparam logic [5:0]  STEP_LAST = STEPS_PER_PHASE - 6'd1;
  localparam logic [19:0] DIE_LAST  = DIE_CYCLES - 20'd1;

  state_e      state_q, state_d;
  logic        alive_q, alive_d;
  logic [19:0] div_q, div_d;
  logic [5:0]  step_q, step_d;
  logic [1:0]  phase_q, phase_d;
  logic [19:0] die_q, die_d;
  logic [9:0]  pos_q, pos_d;
  logic        tick_q, tick_d;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ALIVE;
      alive_q <= 1'b1;
      div_q   <= '0;
      step_q  <= '0;
      phase_q <= '0;
      die_q   <= '0;
      pos_q   <= START_X;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alive_q <= alive_d;
      div_q   <= div_d;
      step_q  <= step_d;
      phase_q <= phase_d;
      die_q   <= die_d;
      pos_q   <= pos_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    step_d  = step_q;
    phase_d = phase_q;
    die_d   = die_q;
    pos_d   = pos_q;
    tick_d  = 1'b0;
    case (state_q)
      ALIVE: begin
        // A kill freezes everything in place, even on the edge that would step.
        if (i_Hit) begin
          state_d = DYING;
          die_d   = '0;
        end else if (i_Enable) begin
          if (div_q == DIV_LAST) begin
            div_d  = '0;
            pos_d  = i_NextHorizontalPosition;
            tick_d = 1'b1;
            if (step_q == STEP_LAST) begin
              step_d  = '0;
              phase_d = phase_q + 2'd1;
            end else begin
              step_d = step_q + 6'd1;
            end
          end else begin
            div_d = div_q + 20'd1;
          end
        end
      end
      DYING: begin
        if (die_q == DIE_LAST) begin
          state_d = DEAD;
          pos_d   = NONE;
        end else begin
          die_d = die_q + 20'd1;
        end
      end
      DEAD: begin
        if (i_Respawn) begin
          state_d = ALIVE;
          pos_d   = START_X;
          phase_d = '0;
          div_d   = '0;
          step_d  = '0;
          die_d   = '0;
        end
      end
      default: state_d = ALIVE;
    endcase
    alive_d = (state_d == ALIVE);
  end

  assign o_EnemyState              = alive_q;
  assign o_EnemyHorizontalPosition = pos_q;
  assign o_PhaseState              = phase_q;
  assign o_MoveTick                = tick_q;

endmodule

// File: tb/tb_enemy_row_controller.sv
// Bench for enemy_row_controller with a small behavioural move stage attached.
module tb_enemy_row_controller;

  logic       clk;
  logic       rst_n;
  logic       en, hit, resp;
  logic [9:0] next_pos;
  logic       alive;
  logic [9:0] pos;
  logic [1:0] ph;
  logic       tick;

  int errors = 0;
  int checks = 0;

  enemy_row_controller #(
    .NONE(10'h3FF), .START_X(10'd100), .MOVE_DIV(20'd4),
    .STEPS_PER_PHASE(6'd2), .DIE_CYCLES(20'd3)
  ) dut (
    .i_Clk(clk),
    .i_Rst_n(rst_n),
    .i_Enable(en),
    .i_Hit(hit),
    .i_Respawn(resp),
    .i_NextHorizontalPosition(next_pos),
    .o_EnemyState(alive),
    .o_EnemyHorizontalPosition(pos),
    .o_PhaseState(ph),
    .o_MoveTick(tick)
  );

  // Move stage: phases 01/10 step right, 00/11 step left.
  assign next_pos = (ph == 2'b01 || ph == 2'b10) ? pos + 10'd1 : pos - 10'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en, hit, resp;
    logic       alive;
    logic [9:0] pos;
    logic [1:0] ph;
    logic       tick;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic e, input logic h, input logic r,
                              input logic a, input logic [9:0] p,
                              input logic [1:0] f, input logic t);
    vec_t v;
    v.en = e; v.hit = h; v.resp = r;
    v.alive = a; v.pos = p; v.ph = f; v.tick = t;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic h, input logic r);
    en = e; hit = h; resp = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic a, input logic [9:0] p,
                         input logic [1:0] f, input logic t);
    chk({tag, ".alive"}, {31'd0, alive}, {31'd0, a});
    chk({tag, ".pos"},   {22'd0, pos},   {22'd0, p});
    chk({tag, ".phase"}, {30'd0, ph},    {30'd0, f});
    chk({tag, ".tick"},  {31'd0, tick},  {31'd0, t});
  endtask

  initial begin
    logic [9:0] sweep_pos [8];
    logic [1:0] sweep_ph  [8];
    logic [9:0] pp;
    logic [1:0] pf;

    sweep_pos = '{10'd99, 10'd98, 10'd99, 10'd100, 10'd101, 10'd102, 10'd101, 10'd100};
    sweep_ph  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    // Full 4-phase sweep: tick every 4th clock.
    pp = 10'd100; pf = 2'd0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 3; j++) add(1, 0, 0, 1, pp, pf, 0);
      add(1, 0, 0, 1, sweep_pos[k], sweep_ph[k], 1);
      pp = sweep_pos[k]; pf = sweep_ph[k];
    end
    // Reach x=99, then kill; dies after 3 clocks even with enable low.
    for (int j = 0; j < 3; j++) add(1, 0, 0, 1, 10'd100, 2'd0, 0);
    add(1, 0, 0, 1, 10'd99, 2'd0, 1);
    add(1, 1, 0, 0, 10'd99, 2'd0, 0);
    add(0, 0, 0, 0, 10'd99, 2'd0, 0);
    add(0, 0, 0, 0, 10'd99, 2'd0, 0);
    add(0, 0, 0, 0, 10'h3FF, 2'd0, 0);
    add(1, 1, 0, 0, 10'h3FF, 2'd0, 0);
    add(1, 1, 1, 1, 10'd100, 2'd0, 0);
    // Respawn while alive must not disturb the divider.
    add(1, 0, 0, 1, 10'd100, 2'd0, 0);
    add(1, 0, 0, 1, 10'd100, 2'd0, 0);
    add(1, 0, 1, 1, 10'd100, 2'd0, 0);
    add(1, 0, 0, 1, 10'd99, 2'd0, 1);
    // Hit coincident with a step: no move, no tick.
    for (int j = 0; j < 3; j++) add(1, 0, 0, 1, 10'd99, 2'd0, 0);
    add(1, 1, 0, 0, 10'd99, 2'd0, 0);
    add(1, 0, 0, 0, 10'd99, 2'd0, 0);
    add(1, 0, 0, 0, 10'd99, 2'd0, 0);
    add(1, 0, 0, 0, 10'h3FF, 2'd0, 0);
    add(0, 0, 1, 1, 10'd100, 2'd0, 0);

    rst_n = 1'b0; en = 1'b0; hit = 1'b0; resp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 1'b1, 10'd100, 2'd0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].en, vecs[i].hit, vecs[i].resp);
      chk_all($sformatf("vec%0d", i), vecs[i].alive, vecs[i].pos, vecs[i].ph, vecs[i].tick);
    end

    // Enable freeze: divider resumes from where it stopped.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int j = 0; j < 10; j++) begin
      cyc(0, 0, 0);
      chk_all($sformatf("freeze%0d", j), 1'b1, 10'd100, 2'd0, 1'b0);
    end
    cyc(1, 0, 0);
    chk_all("resume_a", 1'b1, 10'd100, 2'd0, 1'b0);
    cyc(1, 0, 0);
    chk_all("resume_b", 1'b1, 10'd99, 2'd0, 1'b1);

    // Move into phase 01 at x=98, kill, then reset asynchronously mid-DYING.
    repeat (4) cyc(1, 0, 0);
    chk_all("pre_kill", 1'b1, 10'd98, 2'd1, 1'b1);
    cyc(1, 1, 0);
    chk_all("dying", 1'b0, 10'd98, 2'd1, 1'b0);
    cyc(0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 1'b1, 10'd100, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 0);
    chk_all("post_rst", 1'b1, 10'd100, 2'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enemy_row_controller.md
ENEMY_ROW_CONTROLLER -- requirements
Module: enemy_row_controller

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NONE, 10'h3FF, off-screen position code.
- START_X, 10'd100, spawn/reset horizontal position.
- MOVE_DIV, 20'd500000, clocks per movement step (>=2).
- STEPS_PER_PHASE, 6'd32, movement steps per phase (>=1).
- DIE_CYCLES, 20'd1000000, clocks spent in DYING (>=1).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- i_Clk, in, 1, system clock.
- i_Rst_n, in, 1, reset.
- i_Enable, in, 1, game running; low freezes movement timing.
- i_Hit, in, 1, one-cycle kill pulse from collision logic.
- i_Respawn, in, 1, one-cycle respawn pulse.
- i_NextHorizontalPosition, in, 10, next position returned by the per-row move stage.
- o_EnemyState, out, 1, 1 = alive; drives the move stage.
- o_EnemyHorizontalPosition, out, 10, registered current position; drives the move stage and renderer.
- o_PhaseState, out, 2, movement phase; drives the move stage.
- o_MoveTick, out, 1, one-cycle pulse marking a committed step.
REQ-003 The block SHALL use one clock, i_Clk; reset i_Rst_n SHALL be asynchronous and active-low.

Function
REQ-004 FSM states SHALL be ALIVE, DYING, DEAD; o_EnemyState = 1 only in ALIVE.
REQ-005 Divider counter (0..MOVE_DIV-1) SHALL advance only when state = ALIVE and i_Enable = 1; otherwise hold.
REQ-006 At an edge where divider = MOVE_DIV-1 (ALIVE, enabled, no i_Hit): divider <= 0, position <= i_NextHorizontalPosition, step counter advances, o_MoveTick <= 1 for exactly one cycle.
REQ-007 Step counter (0..STEPS_PER_PHASE-1) SHALL wrap to 0 at STEPS_PER_PHASE-1 and on wrap o_PhaseState SHALL increment modulo 4 (00->01->10->11->00).
REQ-008 Phase semantics of the move stage: 00/11 = left (-1), 01/10 = right (+1); net displacement per full 4-phase cycle SHALL be zero.
REQ-009 START_X SHALL satisfy START_X >= STEPS_PER_PHASE and START_X + STEPS_PER_PHASE <= 639; no 10-bit wrap-around is permitted in legal configurations.
REQ-010 i_Hit in ALIVE: next state DYING, die counter <= 0, position held, divider/step/phase held; i_Hit SHALL take priority over a coincident step (no position load, no o_MoveTick).
REQ-011 i_Hit in DYING or DEAD SHALL be ignored.
REQ-012 DYING: die counter increments each clock regardless of i_Enable; after DIE_CYCLES clocks in DYING, state <= DEAD and position <= NONE.
REQ-013 DEAD: position = NONE, o_MoveTick = 0; i_Respawn -> ALIVE with position <= START_X, phase <= 00, divider, step and die counters <= 0.
REQ-014 i_Respawn in ALIVE or DYING SHALL be ignored; simultaneous i_Hit and i_Respawn in DEAD SHALL respawn.
REQ-015 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-016 While i_Rst_n = 0: state ALIVE, o_EnemyState = 1, o_EnemyHorizontalPosition = START_X, o_PhaseState = 00, o_MoveTick = 0, all counters 0; applies immediately, including mid-DYING.

Verification (MOVE_DIV=4, STEPS_PER_PHASE=2, DIE_CYCLES=3, START_X=100, move stage connected)
REQ-017 Reset release, i_Enable=1 -> o_MoveTick every 4 clocks; positions 99,98 (phase 00), 99,100 (01), 101,102 (10), 101,100 (11), then phase 00.
REQ-018 i_Hit at position 99 -> o_EnemyState = 0 next cycle, position 99 for 3 clocks, then NONE (0x3FF) in DEAD.
REQ-019 i_Hit on a divider = 3 cycle -> no o_MoveTick, position unchanged, step counter unchanged.
REQ-020 i_Respawn in DEAD -> next cycle state 1, position 100, phase 00; i_Respawn in ALIVE -> no change.
REQ-021 i_Enable low for 10 clocks in ALIVE -> no o_MoveTick, divider/position/phase frozen; resumes from same divider value.
REQ-022 i_Rst_n asserted mid-DYING -> immediately ALIVE, position 100, phase 00, o_MoveTick = 0.
